// File: rtl/uv_dam_mb.sv
// rtl/uv_dam_mb.sv - dual-port multi-bank directly accessed memory with per-bank round-robin
//
// Two independent request/response ports share BANK_NUM single-port SRAM banks.
// Word-interleaved (INTERLEAVE=1) or contiguous (INTERLEAVE=0) bank mapping.
//
// Ports (x = a|b):
//   clk, rst                    clock, asynchronous active-high reset
//   port_x_req_vld/rdy          request handshake (rdy is combinational)
//   port_x_req_read             1 = read, 0 = write
//   port_x_req_addr             byte address
//   port_x_req_mask/data        byte write enables / write data
//   port_x_rsp_vld/rdy          response handshake
//   port_x_rsp_excp             00 ok, 01 misaligned, 10 out of range
//   port_x_rsp_data             read data, 0 for writes and exceptions
module uv_dam_mb #(
    parameter int PORT_AW    = 16,
    parameter int PORT_DW    = 32,
    parameter int PORT_MW    = PORT_DW / 8,
    parameter int BANK_NUM   = 4,
    parameter int BANK_DP    = 2 ** (PORT_AW - $clog2(PORT_MW) - $clog2(BANK_NUM)),
    parameter int INTERLEAVE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               port_a_req_vld,
    output logic               port_a_req_rdy,
    input  logic               port_a_req_read,
    input  logic [PORT_AW-1:0] port_a_req_addr,
    input  logic [PORT_MW-1:0] port_a_req_mask,
    input  logic [PORT_DW-1:0] port_a_req_data,
    output logic               port_a_rsp_vld,
    input  logic               port_a_rsp_rdy,
    output logic [1:0]         port_a_rsp_excp,
    output logic [PORT_DW-1:0] port_a_rsp_data,
    input  logic               port_b_req_vld,
    output logic               port_b_req_rdy,
    input  logic               port_b_req_read,
    input  logic [PORT_AW-1:0] port_b_req_addr,
    input  logic [PORT_MW-1:0] port_b_req_mask,
    input  logic [PORT_DW-1:0] port_b_req_data,
    output logic               port_b_rsp_vld,
    input  logic               port_b_rsp_rdy,
    output logic [1:0]         port_b_rsp_excp,
    output logic [PORT_DW-1:0] port_b_rsp_data
);
    localparam int LMW = $clog2(PORT_MW);
    localparam int WW  = PORT_AW - LMW;
    localparam int LB  = $clog2(BANK_NUM);
    localparam int LD  = $clog2(BANK_DP);
    // One extra bit so that a memory covering the whole address space still compares correctly.
    localparam logic [WW:0] TOTAL_W = (WW + 1)'(BANK_NUM * BANK_DP);

    logic [1:0]          vld, rd, rsp_rdy, rsp_vld, slot_free, exc, cand, granted, accept;
    logic [PORT_AW-1:0]  addr      [2];
    logic [PORT_MW-1:0]  mask      [2];
    logic [PORT_DW-1:0]  wdata     [2];
    logic [PORT_DW-1:0]  rdata     [2];
    logic [1:0]          excp_code [2];
    logic [1:0]          rsp_excp  [2];
    logic [LB-1:0]       bank      [2];
    logic [LD-1:0]       row       [2];
    logic [BANK_NUM-1:0] gnt_a, gnt_b, rr, rr_nxt;
    logic [PORT_DW-1:0]  bank_q    [BANK_NUM];

    assign vld      = {port_b_req_vld, port_a_req_vld};
    assign rd       = {port_b_req_read, port_a_req_read};
    assign rsp_rdy  = {port_b_rsp_rdy, port_a_rsp_rdy};
    assign addr[0]  = port_a_req_addr;
    assign addr[1]  = port_b_req_addr;
    assign mask[0]  = port_a_req_mask;
    assign mask[1]  = port_b_req_mask;
    assign wdata[0] = port_a_req_data;
    assign wdata[1] = port_b_req_data;

    assign port_a_req_rdy  = accept[0];
    assign port_a_rsp_vld  = rsp_vld[0];
    assign port_a_rsp_excp = rsp_excp[0];
    assign port_a_rsp_data = rdata[0];
    assign port_b_req_rdy  = accept[1];
    assign port_b_rsp_vld  = rsp_vld[1];
    assign port_b_rsp_excp = rsp_excp[1];
    assign port_b_rsp_data = rdata[1];

    // A port may take a new request when its response slot is empty or drains this cycle.
    assign slot_free = ~rsp_vld | rsp_rdy;
    assign granted   = {|gnt_b, |gnt_a};

    for (genvar p = 0; p < 2; p++) begin : g_dec
        logic [WW-1:0] w;
        logic          mis, oor;

        assign w   = addr[p][PORT_AW-1:LMW];
        assign mis = addr[p][LMW-1:0] != '0;
        assign oor = {1'b0, w} >= TOTAL_W;

        assign excp_code[p] = mis ? 2'b01 : (oor ? 2'b10 : 2'b00);
        assign exc[p]       = mis | oor;

        if (INTERLEAVE != 0) begin : g_il
            assign bank[p] = w[LB-1:0];
            assign row[p]  = LD'(w >> LB);
        end else begin : g_ct
            assign bank[p] = LB'(w >> LD);
            assign row[p]  = w[LD-1:0];
        end

        // Excepting requests bypass arbitration entirely and never touch a bank.
        assign cand[p]   = ~rst & vld[p] & slot_free[p] & ~exc[p];
        assign accept[p] = ~rst & vld[p] & slot_free[p] & (granted[p] | exc[p]);
    end

    // rr[b] = 0 favours port A on bank b; after a conflict it flips to favour the loser.
    always_comb begin
        gnt_a  = '0;
        gnt_b  = '0;
        rr_nxt = rr;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (cand[0] && cand[1] && (bank[0] == LB'(b)) && (bank[1] == LB'(b))) begin
                if (rr[b]) begin
                    gnt_b[b]  = 1'b1;
                    rr_nxt[b] = 1'b0;
                end else begin
                    gnt_a[b]  = 1'b1;
                    rr_nxt[b] = 1'b1;
                end
            end else begin
                gnt_a[b] = cand[0] && (bank[0] == LB'(b));
                gnt_b[b] = cand[1] && (bank[1] == LB'(b));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= '0;
        end else begin
            rr <= rr_nxt;
        end
    end

    for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
        logic               ce, we, sel_b;
        logic [LD-1:0]      ra;
        logic [PORT_DW-1:0] d, q;
        logic [PORT_MW-1:0] m;
        logic [PORT_DW-1:0] mem [BANK_DP];

        assign sel_b = gnt_b[g];
        assign ce    = gnt_a[g] | gnt_b[g];
        assign we    = ce & ~(sel_b ? rd[1] : rd[0]);
        assign ra    = sel_b ? row[1] : row[0];
        assign d     = sel_b ? wdata[1] : wdata[0];
        assign m     = sel_b ? mask[1] : mask[0];

        // q only moves on reads, so a write by the other port leaves a pending read's data intact.
        always_ff @(posedge clk) begin
            if (ce) begin
                if (we) begin
                    for (int i = 0; i < PORT_MW; i++) begin
                        if (m[i]) begin
                            mem[ra][i*8 +: 8] <= d[i*8 +: 8];
                        end
                    end
                end else begin
                    q <= mem[ra];
                end
            end
        end

        assign bank_q[g] = q;
    end

    for (genvar p = 0; p < 2; p++) begin : g_rsp
        logic               vld_r, from_q, held;
        logic [1:0]         excp_r;
        logic [LB-1:0]      src;
        logic [PORT_DW-1:0] hold;

        // Read data is taken straight from bank q in the first response cycle; if not drained
        // then, it is frozen in hold before the bank can be reused by anyone.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_r  <= 1'b0;
                excp_r <= 2'b00;
                from_q <= 1'b0;
                held   <= 1'b0;
                src    <= '0;
                hold   <= '0;
            end else if (accept[p]) begin
                vld_r  <= 1'b1;
                excp_r <= excp_code[p];
                from_q <= rd[p] & ~exc[p];
                held   <= 1'b0;
                src    <= bank[p];
                hold   <= '0;
            end else if (vld_r && rsp_rdy[p]) begin
                vld_r  <= 1'b0;
                excp_r <= 2'b00;
                from_q <= 1'b0;
                held   <= 1'b0;
                hold   <= '0;
            end else if (vld_r && !held) begin
                held <= 1'b1;
                hold <= from_q ? bank_q[src] : '0;
            end
        end

        assign rsp_vld[p]  = vld_r;
        assign rsp_excp[p] = excp_r;
        assign rdata[p]    = (from_q && !held) ? bank_q[src] : hold;
    end
endmodule

// File: tb/tb_uv_dam_mb.sv
// tb/tb_uv_dam_mb.sv - self-checking bench for uv_dam_mb with a flat-memory reference model
module tb_uv_dam_mb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index [i][p]: i = 0 interleaved instance, i = 1 contiguous instance with 8-word banks.
    logic        t_vld     [2][2];
    logic        t_read    [2][2];
    logic [15:0] t_addr    [2][2];
    logic [3:0]  t_mask    [2][2];
    logic [31:0] t_wdata   [2][2];
    logic        t_rsp_rdy [2][2];
    logic        o_rdy     [2][2];
    logic        o_vld     [2][2];
    logic [1:0]  o_excp    [2][2];
    logic [31:0] o_data    [2][2];

    uv_dam_mb #(.PORT_AW(16), .PORT_DW(32), .BANK_NUM(4), .INTERLEAVE(1)) u_il (
        .clk(clk), .rst(rst),
        .port_a_req_vld(t_vld[0][0]), .port_a_req_rdy(o_rdy[0][0]), .port_a_req_read(t_read[0][0]),
        .port_a_req_addr(t_addr[0][0]), .port_a_req_mask(t_mask[0][0]), .port_a_req_data(t_wdata[0][0]),
        .port_a_rsp_vld(o_vld[0][0]), .port_a_rsp_rdy(t_rsp_rdy[0][0]), .port_a_rsp_excp(o_excp[0][0]),
        .port_a_rsp_data(o_data[0][0]),
        .port_b_req_vld(t_vld[0][1]), .port_b_req_rdy(o_rdy[0][1]), .port_b_req_read(t_read[0][1]),
        .port_b_req_addr(t_addr[0][1]), .port_b_req_mask(t_mask[0][1]), .port_b_req_data(t_wdata[0][1]),
        .port_b_rsp_vld(o_vld[0][1]), .port_b_rsp_rdy(t_rsp_rdy[0][1]), .port_b_rsp_excp(o_excp[0][1]),
        .port_b_rsp_data(o_data[0][1])
    );

    uv_dam_mb #(.PORT_AW(16), .PORT_DW(32), .BANK_NUM(4), .BANK_DP(8), .INTERLEAVE(0)) u_ct (
        .clk(clk), .rst(rst),
        .port_a_req_vld(t_vld[1][0]), .port_a_req_rdy(o_rdy[1][0]), .port_a_req_read(t_read[1][0]),
        .port_a_req_addr(t_addr[1][0]), .port_a_req_mask(t_mask[1][0]), .port_a_req_data(t_wdata[1][0]),
        .port_a_rsp_vld(o_vld[1][0]), .port_a_rsp_rdy(t_rsp_rdy[1][0]), .port_a_rsp_excp(o_excp[1][0]),
        .port_a_rsp_data(o_data[1][0]),
        .port_b_req_vld(t_vld[1][1]), .port_b_req_rdy(o_rdy[1][1]), .port_b_req_read(t_read[1][1]),
        .port_b_req_addr(t_addr[1][1]), .port_b_req_mask(t_mask[1][1]), .port_b_req_data(t_wdata[1][1]),
        .port_b_rsp_vld(o_vld[1][1]), .port_b_rsp_rdy(t_rsp_rdy[1][1]), .port_b_rsp_excp(o_excp[1][1]),
        .port_b_rsp_data(o_data[1][1])
    );

    int          nvec = 0;
    int          nmis = 0;
    logic [31:0] mem_m [int];   // key = i*65536 + word index; present only when fully known
    bit          favour  [8];   // per instance/bank: 0 = A wins next conflict
    bit          pend    [2][2];
    logic [1:0]  p_excp  [2][2];
    logic [31:0] p_data  [2][2];
    bit          p_known [2][2];
    bit          acc     [2][2];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] excp_of(int i, logic [15:0] a);
        if (a[1:0] != 2'b00) return 2'b01;
        if (int'(a) / 4 >= ((i == 0) ? 4 * 4096 : 4 * 8)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int bank_of(int i, int w);
        return (i == 0) ? (w % 4) : (w / 8);
    endfunction

    task automatic write_model(int key, logic [3:0] m, logic [31:0] d);
        logic [31:0] v;
        if (m == 4'hF) begin
            mem_m[key] = d;
        end else if (mem_m.exists(key)) begin
            v = mem_m[key];
            for (int k = 0; k < 4; k++) if (m[k]) v[k*8 +: 8] = d[k*8 +: 8];
            mem_m[key] = v;
        end
    endtask

    // Evaluate the current cycle against the model, then advance the model as the clock edge will.
    task automatic settle();
        bit         free [2];
        bit         cand [2];
        bit         er   [2];
        int         bk   [2];
        int         w    [2];
        logic [1:0] ec   [2];
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int p = 0; p < 2; p++) pend[i][p] = 0;
                for (int b = 0; b < 4; b++) favour[i*4 + b] = 0;
            end
            for (int p = 0; p < 2; p++) begin
                w[p]    = int'(t_addr[i][p]) / 4;
                ec[p]   = excp_of(i, t_addr[i][p]);
                bk[p]   = bank_of(i, w[p]);
                free[p] = !pend[i][p] || t_rsp_rdy[i][p];
                cand[p] = !rst && t_vld[i][p] && free[p] && (ec[p] == 2'b00);
                er[p]   = !rst && t_vld[i][p] && free[p] && ((ec[p] != 2'b00) || cand[p]);
            end
            if (cand[0] && cand[1] && bk[0] == bk[1]) begin
                if (!favour[i*4 + bk[0]]) begin
                    er[1] = 0;
                    favour[i*4 + bk[0]] = 1;
                end else begin
                    er[0] = 0;
                    favour[i*4 + bk[0]] = 0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("i%0d p%0d req_rdy", i, p), 64'(o_rdy[i][p]), 64'(er[p]));
                chk($sformatf("i%0d p%0d rsp_vld", i, p), 64'(o_vld[i][p]), 64'(pend[i][p]));
                if (pend[i][p]) begin
                    chk($sformatf("i%0d p%0d rsp_excp", i, p), 64'(o_excp[i][p]), 64'(p_excp[i][p]));
                    if (p_known[i][p])
                        chk($sformatf("i%0d p%0d rsp_data", i, p), 64'(o_data[i][p]), 64'(p_data[i][p]));
                end
            end
            for (int p = 0; p < 2; p++) if (pend[i][p] && t_rsp_rdy[i][p]) pend[i][p] = 0;
            for (int p = 0; p < 2; p++) begin
                if (er[p]) begin
                    pend[i][p]   = 1;
                    p_excp[i][p] = ec[p];
                    if (ec[p] == 2'b00 && t_read[i][p]) begin
                        p_known[i][p] = mem_m.exists(i * 65536 + w[p]);
                        p_data[i][p]  = p_known[i][p] ? mem_m[i * 65536 + w[p]] : 32'h0;
                    end else begin
                        p_known[i][p] = 1;
                        p_data[i][p]  = 32'h0;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (er[p] && ec[p] == 2'b00 && !t_read[i][p])
                    write_model(i * 65536 + w[p], t_mask[i][p], t_wdata[i][p]);
                acc[i][p] = er[p];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(int i, int p, bit r, logic [15:0] a, logic [3:0] m, logic [31:0] d);
        t_vld[i][p]   = 1'b1;
        t_read[i][p]  = r;
        t_addr[i][p]  = a;
        t_mask[i][p]  = m;
        t_wdata[i][p] = d;
    endtask

    task automatic idle(int i, int p);
        t_vld[i][p] = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr(int i);
        int          r;
        logic [15:0] a;
        r = $urandom_range(0, 99);
        a = 16'($urandom_range(0, (i == 0) ? 15 : 31) * 4);
        if (r < 8) a = a + 16'($urandom_range(1, 3));
        else if (i == 1 && r < 18) a = 16'(128 + $urandom_range(0, 1000) * 4);
        return a;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                t_vld[i][p] = 0; t_read[i][p] = 0; t_addr[i][p] = '0;
                t_mask[i][p] = '0; t_wdata[i][p] = '0; t_rsp_rdy[i][p] = 1;
                pend[i][p] = 0; acc[i][p] = 0; p_known[i][p] = 0;
            end
        end
        for (int b = 0; b < 8; b++) favour[b] = 0;

        // Reset: a valid request must not be accepted while rst is high.
        rst = 1'b1;
        req(0, 0, 1, 16'h0000, 4'hF, 32'h0);
        tick(); tick();
        settle();
        chk("rst_data_a", 64'(o_data[0][0]), 64'h0);
        chk("rst_excp_a", 64'(o_excp[0][0]), 64'h0);
        chk("rst_data_b_ct", 64'(o_data[1][1]), 64'h0);
        tick();
        rst = 1'b0;
        idle(0, 0);

        // Basic write then read with one-cycle latency.
        req(0, 0, 0, 16'h0000, 4'hF, 32'hDEADBEEF);
        settle(); chk("t1_wr_rdy", 64'(o_rdy[0][0]), 64'h1); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle(); chk("t1_rd_rdy", 64'(o_rdy[0][0]), 64'h1); tick();
        idle(0, 0);
        settle();
        chk("t1_rsp_vld", 64'(o_vld[0][0]), 64'h1);
        chk("t1_rsp_data", 64'(o_data[0][0]), 64'hDEADBEEF);
        chk("t1_rsp_excp", 64'(o_excp[0][0]), 64'h0);
        tick();

        // Parallel accesses to different banks.
        req(0, 0, 0, 16'h0004, 4'hF, 32'h0BADF00D);
        settle(); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        req(0, 1, 1, 16'h0004, 4'h0, 32'h0);
        settle();
        chk("t2_rdy_a", 64'(o_rdy[0][0]), 64'h1);
        chk("t2_rdy_b", 64'(o_rdy[0][1]), 64'h1);
        tick();
        idle(0, 0); idle(0, 1);
        settle();
        chk("t2_data_b", 64'(o_data[0][1]), 64'h0BADF00D);
        tick();

        // Bank-0 conflicts: first goes A then B, second goes B then A.
        req(0, 1, 0, 16'h0010, 4'hF, 32'hCAFE0010);
        settle(); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        req(0, 1, 1, 16'h0010, 4'h0, 32'h0);
        settle();
        chk("t3_c1_rdy_a", 64'(o_rdy[0][0]), 64'h1);
        chk("t3_c1_rdy_b", 64'(o_rdy[0][1]), 64'h0);
        tick();
        idle(0, 0);
        settle(); chk("t3_c1_late_b", 64'(o_rdy[0][1]), 64'h1); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle();
        chk("t3_c2_rdy_a", 64'(o_rdy[0][0]), 64'h0);
        chk("t3_c2_rdy_b", 64'(o_rdy[0][1]), 64'h1);
        tick();
        idle(0, 1);
        settle(); chk("t3_c2_late_a", 64'(o_rdy[0][0]), 64'h1); tick();
        idle(0, 0);
        settle(); tick();

        // Backpressure: A's read data must survive B writing the same word.
        req(0, 0, 0, 16'h0000, 4'hF, 32'h11223344);
        settle(); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle(); tick();
        t_rsp_rdy[0][0] = 1'b0;
        req(0, 1, 0, 16'h0000, 4'hF, 32'h00000055);
        settle();
        chk("t4_c1_data", 64'(o_data[0][0]), 64'h11223344);
        chk("t4_c1_rdy_a", 64'(o_rdy[0][0]), 64'h0);
        chk("t4_c1_rdy_b", 64'(o_rdy[0][1]), 64'h1);
        tick();
        idle(0, 1);
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("t4_hold_data", 64'(o_data[0][0]), 64'h11223344);
            chk("t4_hold_rdy_a", 64'(o_rdy[0][0]), 64'h0);
            tick();
        end
        t_rsp_rdy[0][0] = 1'b1;
        settle();
        chk("t4_drain_data", 64'(o_data[0][0]), 64'h11223344);
        chk("t4_b2b_rdy_a", 64'(o_rdy[0][0]), 64'h1);
        tick();
        idle(0, 0);
        settle(); chk("t4_new_data", 64'(o_data[0][0]), 64'h00000055); tick();

        // Byte mask and exceptions.
        req(0, 0, 0, 16'h0000, 4'hF, 32'h11223344);
        settle(); tick();
        req(0, 0, 0, 16'h0000, 4'b0010, 32'hAABBCCDD);
        settle(); tick();
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle(); tick();
        req(0, 0, 1, 16'h0002, 4'h0, 32'h0);
        settle();
        chk("t5_mask_data", 64'(o_data[0][0]), 64'h1122CC44);
        chk("t5_mis_rdy", 64'(o_rdy[0][0]), 64'h1);
        tick();
        idle(0, 0);
        req(1, 0, 1, 16'h0080, 4'h0, 32'h0);
        settle();
        chk("t5_mis_excp", 64'(o_excp[0][0]), 64'h1);
        chk("t5_mis_data", 64'(o_data[0][0]), 64'h0);
        chk("t5_oor_rdy", 64'(o_rdy[1][0]), 64'h1);
        tick();
        idle(1, 0);
        settle();
        chk("t5_oor_excp", 64'(o_excp[1][0]), 64'h2);
        chk("t5_oor_data", 64'(o_data[1][0]), 64'h0);
        tick();

        // Reset while a response is stalled; memory must survive.
        t_rsp_rdy[0][0] = 1'b0;
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle(); tick();
        idle(0, 0);
        settle(); chk("t6_pre_vld", 64'(o_vld[0][0]), 64'h1);
        rst = 1'b1;
        #1;
        chk("t6_rst_drop", 64'(o_vld[0][0]), 64'h0);
        settle(); tick();
        settle(); tick();
        rst = 1'b0;
        t_rsp_rdy[0][0] = 1'b1;
        req(0, 0, 1, 16'h0000, 4'h0, 32'h0);
        settle(); chk("t6_post_rdy", 64'(o_rdy[0][0]), 64'h1); tick();
        idle(0, 0);
        settle(); chk("t6_retained", 64'(o_data[0][0]), 64'h1122CC44); tick();

        // Fill every word the random phase touches so every read has a known value.
        for (int k = 0; k < 32; k++) begin
            req(0, 0, 0, 16'((k % 16) * 4), 4'hF, $urandom);
            req(1, 0, 0, 16'(k * 4), 4'hF, $urandom);
            settle(); tick();
        end
        idle(0, 0); idle(1, 0);
        settle(); tick();

        // Random traffic on both instances; requests are held until accepted.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!t_vld[i][p] || acc[i][p]) begin
                        if ($urandom_range(0, 9) < 7)
                            req(i, p, 1'($urandom_range(0, 1)), rand_addr(i), 4'($urandom), $urandom);
                        else
                            idle(i, p);
                    end
                    t_rsp_rdy[i][p] = ($urandom_range(0, 9) < 6);
                end
            end
            settle(); tick();
        end
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                idle(i, p);
                t_rsp_rdy[i][p] = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            settle(); tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
